// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one non-pipelined memory port between the data (LSU) and fetch requesters
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter bit DATA_FIRST   = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        d_req_valid_i,
  output logic        d_req_ready_o,
  input  logic [71:0] d_req_i,
  output logic        d_rsp_valid_o,
  input  logic        i_req_valid_i,
  output logic        i_req_ready_o,
  input  logic [31:0] i_req_addr_i,
  output logic        i_rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_error_o,
  output logic        m_req_valid_o,
  input  logic        m_req_ready_i,
  output logic [71:0] m_req_o,
  input  logic        m_rsp_valid_i,
  input  logic [31:0] m_rsp_data_i,
  input  logic        m_rsp_error_i
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t        r_state, w_state_nxt;
  logic          r_owner;
  logic [CW-1:0] r_starve;
  logic [71:0]   r_m_req;
  logic          w_force, w_grant_d, w_grant_i, w_grant, w_def_grant, w_other_valid, w_rsp;
  assign w_force       = r_starve == CW'(STARVE_LIMIT);
  assign w_grant       = w_grant_d | w_grant_i;
  assign w_def_grant   = DATA_FIRST ? w_grant_d : w_grant_i;
  assign w_other_valid = DATA_FIRST ? i_req_valid_i : d_req_valid_i;
  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    w_rsp       = 1'b0;
    case (r_state)
      IDLE: begin
        // with both valid the default side wins unless the other side has waited STARVE_LIMIT grants
        w_grant_d = d_req_valid_i & (!i_req_valid_i | (DATA_FIRST ? !w_force : w_force));
        w_grant_i = i_req_valid_i & !w_grant_d;
        w_state_nxt = (w_grant_d | w_grant_i) ? REQ : IDLE;
      end
      REQ: w_state_nxt = m_req_ready_i ? RSP : REQ;
      RSP: begin
        w_rsp       = m_rsp_valid_i;
        w_state_nxt = m_rsp_valid_i ? IDLE : RSP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_starve <= '0;
      r_m_req  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner  <= w_grant_i;
        r_m_req  <= w_grant_d ? d_req_i : {1'b0, 3'b010, 4'b0000, 32'h0, i_req_addr_i};
        r_starve <= (w_def_grant && w_other_valid) ? (w_force ? r_starve : r_starve + 1'b1) : '0;
      end
    end
  end
  assign d_req_ready_o = w_grant_d;
  assign i_req_ready_o = w_grant_i;
  assign m_req_valid_o = r_state == REQ;
  assign m_req_o       = r_m_req;
  assign d_rsp_valid_o = w_rsp & !r_owner;
  assign i_rsp_valid_o = w_rsp & r_owner;
  assign rsp_data_o    = w_rsp ? m_rsp_data_i : '0;
  assign rsp_error_o   = w_rsp & m_rsp_error_i;
endmodule
